// File: rtl/zigzag_block_sequencer_if.sv
// Handshake and data bundle between the zigzag block sequencer and its
// neighbours: block requests, zigzag buffer load/data, and the coefficient stream.
interface zigzag_block_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned NUM_COEF   = 64
);
  localparam int unsigned IW = $clog2(NUM_COEF);

  logic                           blk_start_valid;
  logic                           blk_start_ready;
  logic                           buf_input_enable;
  logic [NUM_COEF*DATA_WIDTH-1:0] zz_pix_in;
  logic                           coef_valid;
  logic                           coef_ready;
  logic [DATA_WIDTH-1:0]          coef_data;
  logic [IW-1:0]                  coef_index;
  logic                           coef_last;
  logic                           busy;
  logic                           blk_done;

  modport slave (
    input  blk_start_valid, zz_pix_in, coef_ready,
    output blk_start_ready, buf_input_enable, coef_valid, coef_data,
           coef_index, coef_last, busy, blk_done
  );

  modport master (
    output blk_start_valid, zz_pix_in, coef_ready,
    input  blk_start_ready, buf_input_enable, coef_valid, coef_data,
           coef_index, coef_last, busy, blk_done
  );
endinterface

// File: rtl/zigzag_block_sequencer.sv
// Loads one 8x8 block into the zigzag buffer, waits out fill/reorder latency,
// snapshots the zigzag vector and streams it as NUM_COEF valid/ready beats.
module zigzag_block_sequencer #(
  parameter int unsigned DATA_WIDTH  = 10,
  parameter int unsigned NUM_COEF    = 64,
  parameter int unsigned LOAD_CYCLES = 11,
  parameter int unsigned ZZ_LATENCY  = 2
) (
  input  logic                    clock,
  input  logic                    reset_n,
  zigzag_block_sequencer_if.slave bus
);
  localparam int unsigned IW     = $clog2(NUM_COEF);
  localparam int unsigned SETTLE = LOAD_CYCLES + ZZ_LATENCY;
  localparam int unsigned CW     = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {L_IDLE, L_RUN, L_HOLD} load_state_e;
  typedef enum logic       {D_IDLE, D_OUT}          drain_state_e;

  load_state_e                         load_q, load_d;
  drain_state_e                        drain_q, drain_d;
  logic [CW-1:0]                       settle_q, settle_d;
  logic [NUM_COEF-1:0][DATA_WIDTH-1:0] snap_q, snap_d;
  logic [IW-1:0]                       idx_q, idx_d;
  logic                                strobe_q, strobe_d;
  logic                                done_q, done_d;

  logic start_fire;
  logic beat_fire;
  logic last_fire;
  logic capture;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      load_q   <= L_IDLE;
      drain_q  <= D_IDLE;
      settle_q <= '0;
      snap_q   <= '0;
      idx_q    <= '0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      load_q   <= load_d;
      drain_q  <= drain_d;
      settle_q <= settle_d;
      snap_q   <= snap_d;
      idx_q    <= idx_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    load_d   = load_q;
    drain_d  = drain_q;
    settle_d = settle_q;
    snap_d   = snap_q;
    idx_d    = idx_q;

    start_fire = (load_q == L_IDLE) && bus.blk_start_valid;
    beat_fire  = (drain_q == D_OUT) && bus.coef_ready;
    last_fire  = beat_fire && (idx_q == IW'(NUM_COEF - 1));
    // A held block may take over in the same edge that retires index 63.
    capture    = (load_q == L_HOLD) && ((drain_q == D_IDLE) || last_fire);

    strobe_d = start_fire;
    done_d   = last_fire;

    case (load_q)
      L_IDLE: begin
        if (start_fire) begin
          load_d   = L_RUN;
          settle_d = '0;
        end
      end
      L_RUN: begin
        if (settle_q == CW'(SETTLE - 1)) begin
          load_d = L_HOLD;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      L_HOLD: begin
        if (capture) begin
          load_d = L_IDLE;
        end
      end
      default: load_d = L_IDLE;
    endcase

    if (capture) begin
      snap_d  = bus.zz_pix_in;
      idx_d   = '0;
      drain_d = D_OUT;
    end else if (last_fire) begin
      drain_d = D_IDLE;
    end else if (beat_fire) begin
      idx_d = idx_q + 1'b1;
    end
  end

  // Coefficient k sits at the top of the vector, i.e. packed element NUM_COEF-1-k.
  always_comb begin
    bus.blk_start_ready  = (load_q == L_IDLE);
    bus.buf_input_enable = strobe_q;
    bus.coef_valid       = (drain_q == D_OUT);
    bus.coef_index       = idx_q;
    bus.coef_data        = snap_q[IW'(NUM_COEF - 1) - idx_q];
    bus.coef_last        = (drain_q == D_OUT) && (idx_q == IW'(NUM_COEF - 1));
    bus.busy             = (load_q != L_IDLE) || (drain_q != D_IDLE) || strobe_q;
    bus.blk_done         = done_q;
  end
endmodule
